// File: rtl/digital_macro_seq_pkg.sv
// Shared types and defaults for the digital macro run sequencer.
package digital_macro_seq_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned STATE_W_DEFAULT = 4;

  typedef enum logic [STATE_W_DEFAULT-1:0] {
    IDLE,
    CFG_EM,
    CFG_FM,
    CFG_AW,
    LOAD,
    RUN,
    DRAIN,
    READOUT,
    DONE,
    ABORT
  } seq_state_e;

endpackage

// File: rtl/digital_macro_seq_down_counter.sv
// Loadable down-counter with a zero flag; times the data-load window.
module seq_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/digital_macro_seq.sv
// Run sequencer for one compute macro: config strobes, data load, annealing
// run with iteration/timeout limits, drain, readout and done/abort reporting.
module digital_macro_seq
  import digital_macro_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned STATE_W = STATE_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               cfg_skip_load_i,
  input  logic [CNT_W-1:0]   cfg_load_cycles_i,
  input  logic [CNT_W-1:0]   cfg_iter_num_i,
  input  logic [CNT_W-1:0]   cfg_timeout_i,
  input  logic               iter_pulse_i,
  input  logic               cmpt_idle_i,
  output logic               en_o,
  output logic               config_valid_em_o,
  output logic               config_valid_fm_o,
  output logic               config_valid_aw_o,
  output logic               dt_cfg_enable_o,
  output logic               cmpt_en_o,
  output logic               flush_o,
  output logic               host_readout_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic               aborted_o,
  output logic [CNT_W-1:0]   iter_cnt_o,
  output logic [STATE_W-1:0] state_o
);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic             skip_q;
  logic [CNT_W-1:0] iter_num_q;
  logic [CNT_W-1:0] timeout_q;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] iter_inc;
  logic [CNT_W-1:0] to_inc;
  logic [CNT_W-1:0] load_val;
  logic             accept;
  logic             iter_hit;
  logic             to_hit;
  logic             load_done;

  assign accept   = (state == IDLE) && start_i;
  assign iter_inc = (iter_cnt_o == '1) ? iter_cnt_o : iter_cnt_o + CNT_W'(1);
  assign to_inc   = to_cnt + CNT_W'(1);
  assign iter_hit = iter_pulse_i && (iter_num_q != '0) && (iter_inc == iter_num_q);
  // A pulse clears the timeout counter, so completion always beats timeout.
  assign to_hit   = !iter_pulse_i && (timeout_q != '0) && (to_inc == timeout_q);
  // Counter holds (cycles - 1); zero-length loads still get one cycle.
  assign load_val = (cfg_load_cycles_i == '0) ? '0 : cfg_load_cycles_i - CNT_W'(1);

  seq_down_counter #(
    .W(CNT_W)
  ) u_load_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (accept),
    .load_val (load_val),
    .dec      ((state == LOAD) && !load_done),
    .zero_c   (load_done)
  );

  always_comb begin
    state_nxt = state;
    if ((state != IDLE) && (state != ABORT) && abort_i) begin
      state_nxt = ABORT;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = CFG_EM;
        CFG_EM:  state_nxt = CFG_FM;
        CFG_FM:  state_nxt = CFG_AW;
        CFG_AW:  state_nxt = skip_q ? RUN : LOAD;
        LOAD:    if (load_done) state_nxt = RUN;
        RUN:     if (iter_hit || to_hit) state_nxt = DRAIN;
        DRAIN:   if (cmpt_idle_i) state_nxt = READOUT;
        READOUT: state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        ABORT:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      state_o           <= '0;
      en_o              <= 1'b0;
      config_valid_em_o <= 1'b0;
      config_valid_fm_o <= 1'b0;
      config_valid_aw_o <= 1'b0;
      dt_cfg_enable_o   <= 1'b0;
      cmpt_en_o         <= 1'b0;
      flush_o           <= 1'b0;
      host_readout_o    <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      timeout_o         <= 1'b0;
      aborted_o         <= 1'b0;
      iter_cnt_o        <= '0;
      to_cnt            <= '0;
      skip_q            <= 1'b0;
      iter_num_q        <= '0;
      timeout_q         <= '0;
    end else begin
      state             <= state_nxt;
      state_o           <= STATE_W'(state_nxt);
      en_o              <= (state_nxt != IDLE) && (state_nxt != ABORT);
      config_valid_em_o <= (state_nxt == CFG_EM);
      config_valid_fm_o <= (state_nxt == CFG_FM);
      config_valid_aw_o <= (state_nxt == CFG_AW);
      dt_cfg_enable_o   <= (state_nxt == LOAD);
      cmpt_en_o         <= (state_nxt == RUN);
      flush_o           <= (state_nxt == ABORT);
      host_readout_o    <= (state_nxt == READOUT);
      busy_o            <= (state_nxt != IDLE);
      done_o            <= (state_nxt == DONE);
      if (accept) begin
        skip_q     <= cfg_skip_load_i;
        iter_num_q <= cfg_iter_num_i;
        timeout_q  <= cfg_timeout_i;
        iter_cnt_o <= '0;
        to_cnt     <= '0;
        timeout_o  <= 1'b0;
        aborted_o  <= 1'b0;
      end else if (state_nxt == ABORT) begin
        aborted_o <= 1'b1;
      end else if (state == RUN) begin
        if (iter_pulse_i) begin
          iter_cnt_o <= iter_inc;
          to_cnt     <= '0;
        end else begin
          to_cnt <= to_inc;
        end
        if (to_hit) timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digital_macro_seq.sv
// Directed and randomized checks of digital_macro_seq against a cycle-level
// phase model built from the sequencing rules.
module tb_digital_macro_seq;

  localparam int unsigned CW = 16;
  localparam int P_IDLE = 0, P_EM = 1, P_FM = 2, P_AW = 3, P_LOAD = 4,
                 P_RUN = 5, P_DRAIN = 6, P_READOUT = 7, P_DONE = 8, P_ABORT = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, abort = 1'b0, skip = 1'b0;
  logic [CW-1:0] load_cycles = '0, iter_num = '0, tmo_cfg = '0;
  logic          iter_pulse = 1'b0, cmpt_idle = 1'b1;
  logic          en, cv_em, cv_fm, cv_aw, dt_en, cmpt_en, flush, readout;
  logic          busy, done, timeout_flag, aborted;
  logic [CW-1:0] iter_cnt;
  logic [3:0]    state;

  digital_macro_seq #(.CNT_W(CW), .STATE_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cfg_skip_load_i(skip), .cfg_load_cycles_i(load_cycles),
    .cfg_iter_num_i(iter_num), .cfg_timeout_i(tmo_cfg),
    .iter_pulse_i(iter_pulse), .cmpt_idle_i(cmpt_idle),
    .en_o(en), .config_valid_em_o(cv_em), .config_valid_fm_o(cv_fm),
    .config_valid_aw_o(cv_aw), .dt_cfg_enable_o(dt_en), .cmpt_en_o(cmpt_en),
    .flush_o(flush), .host_readout_o(readout), .busy_o(busy), .done_o(done),
    .timeout_o(timeout_flag), .aborted_o(aborted), .iter_cnt_o(iter_cnt),
    .state_o(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, cyc = 0;
  int n_dt, n_cmpt, n_done, n_readout, n_flush;

  // Reference model: current phase, latched job parameters, progress counts.
  int m_ph = P_IDLE, m_iter = 0, m_since = 0, m_load_seen = 0;
  int m_load = 0, m_iter_cfg = 0, m_tmo_cfg = 0;
  bit m_skip = 0, m_tmo = 0, m_abt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ph = P_IDLE; m_iter = 0; m_since = 0; m_tmo = 0; m_abt = 0;
      return;
    end
    if (m_ph == P_IDLE) begin
      if (start) begin
        m_load = int'(load_cycles); m_iter_cfg = int'(iter_num);
        m_tmo_cfg = int'(tmo_cfg); m_skip = skip;
        m_iter = 0; m_since = 0; m_load_seen = 0; m_tmo = 0; m_abt = 0;
        m_ph = P_EM;
      end
    end else if (abort && m_ph != P_ABORT) begin
      m_ph = P_ABORT; m_abt = 1;
    end else begin
      case (m_ph)
        P_EM: m_ph = P_FM;
        P_FM: m_ph = P_AW;
        P_AW: m_ph = m_skip ? P_RUN : P_LOAD;
        P_LOAD: begin
          m_load_seen++;
          if (m_load_seen >= ((m_load == 0) ? 1 : m_load)) m_ph = P_RUN;
        end
        P_RUN: begin
          if (iter_pulse) begin
            if (m_iter < (1 << CW) - 1) m_iter++;
            m_since = 0;
            if (m_iter_cfg != 0 && m_iter == m_iter_cfg) m_ph = P_DRAIN;
          end else begin
            m_since++;
            if (m_tmo_cfg != 0 && m_since == m_tmo_cfg) begin
              m_ph = P_DRAIN; m_tmo = 1;
            end
          end
        end
        P_DRAIN: if (cmpt_idle) m_ph = P_READOUT;
        P_READOUT: m_ph = P_DONE;
        P_DONE: m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [11:0] model_outs();
    return {m_ph != P_IDLE && m_ph != P_ABORT, m_ph == P_EM, m_ph == P_FM,
            m_ph == P_AW, m_ph == P_LOAD, m_ph == P_RUN, m_ph == P_ABORT,
            m_ph == P_READOUT, m_ph != P_IDLE, m_ph == P_DONE, m_tmo, m_abt};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("outs", {en, cv_em, cv_fm, cv_aw, dt_en, cmpt_en, flush, readout,
                   busy, done, timeout_flag, aborted}, model_outs());
    check("iter_cnt", iter_cnt, m_iter);
    check("state", state, m_ph);
    n_dt += dt_en; n_cmpt += cmpt_en; n_done += done;
    n_readout += readout; n_flush += flush;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    n_dt = 0; n_cmpt = 0; n_done = 0; n_readout = 0; n_flush = 0;
  endtask

  task automatic job(input bit sk, input int ld, input int it, input int to);
    skip = sk; load_cycles = CW'(ld); iter_num = CW'(it); tmo_cfg = CW'(to);
    clr();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse();
    iter_pulse = 1'b1; step(); iter_pulse = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1; steps(2); rst = 1'b0; step();
    check("reset_busy", busy, 1'b0);

    // Nominal run: load 3, two iterations; cfg changed after start must not matter
    cmpt_idle = 1'b1;
    job(1'b0, 3, 2, 0);
    check("nom_em_first", cv_em, 1'b1);
    load_cycles = CW'(9); iter_num = CW'(7);
    steps(8); pulse(); steps(3); pulse(); steps(6);
    check("nom_dt_cycles", n_dt, 3);
    check("nom_cmpt_cycles", n_cmpt, 7);
    check("nom_readout", n_readout, 1);
    check("nom_done", n_done, 1);
    check("nom_iter_cnt", iter_cnt, 2);

    // Skip load, then zero-length load still gives one cycle
    job(1'b1, 0, 1, 0); steps(3); pulse(); steps(4);
    check("skip_dt_cycles", n_dt, 0);
    check("skip_done", n_done, 1);
    job(1'b0, 0, 1, 0); steps(4); pulse(); steps(4);
    check("load0_dt_cycles", n_dt, 1);

    // Timeout with no iteration pulses
    job(1'b1, 0, 5, 4); steps(12);
    check("tmo_cmpt_cycles", n_cmpt, 4);
    check("tmo_flag", timeout_flag, 1'b1);
    check("tmo_done", n_done, 1);
    check("tmo_iter_cnt", iter_cnt, 0);

    // Abort on third LOAD cycle
    job(1'b0, 8, 1, 0); steps(5);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_flush", flush, 1'b1);
    check("abort_dt", dt_en, 1'b0);
    check("abort_en", en, 1'b0);
    check("abort_flag", aborted, 1'b1);
    steps(4);
    check("abort_no_done", n_done, 0);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_idle_ignored", busy, 1'b0);
    job(1'b1, 0, 1, 0);
    check("abort_cleared", aborted, 1'b0);
    steps(3); pulse(); steps(4);

    // Drain holds until compute reports idle
    job(1'b1, 0, 1, 0); steps(3);
    cmpt_idle = 1'b0; pulse(); steps(6);
    check("drain_hold_state", state, P_DRAIN);
    check("drain_no_readout", n_readout, 0);
    cmpt_idle = 1'b1; steps(4);
    check("drain_readout", n_readout, 1);

    // Synchronous reset during RUN, start during reset ignored
    job(1'b1, 0, 0, 0); steps(4);
    rst = 1'b1; start = 1'b1; step();
    check("rst_busy", busy, 1'b0);
    check("rst_flush", flush, 1'b0);
    step(); rst = 1'b0; start = 1'b0; step();
    check("rst_start_ignored", busy, 1'b0);
    job(1'b0, 2, 1, 0); steps(5); pulse(); steps(4);
    check("rst_next_done", n_done, 1);

    // Randomized traffic, including mid-job cfg changes, aborts and resets
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      iter_pulse = ($urandom_range(0, 2) == 0);
      cmpt_idle  = 1'($urandom_range(0, 1));
      skip       = 1'($urandom_range(0, 1));
      load_cycles = CW'($urandom_range(0, 5));
      iter_num    = CW'($urandom_range(0, 4));
      tmo_cfg     = CW'($urandom_range(0, 6));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
